lane_render_ctrl: RTL and testbench



---
 rtl/lane_render_ctrl_pkg.sv | 73 +++++++
 rtl/lane_render_ctrl_scanner.sv | 52 +++++
 rtl/lane_render_ctrl.sv | 150 +++++++++++++++
 tb/tb_lane_render_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lane_render_ctrl_pkg.sv
// Shared encodings and geometry for the lane renderer: screen modes, FSM
// states, colours, screen/sprite dimensions and lane-decoding helpers.
package lane_render_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_BLANK = 2'd0,
        MODE_START = 2'd1,
        MODE_GAME  = 2'd2,
        MODE_END   = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_ERASE_OBS = 3'd2,
        ST_ERASE_PLR = 3'd3,
        ST_DRAW_OBS  = 3'd4,
        ST_DRAW_PLR  = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    localparam int SCREEN_W   = 160;
    localparam int SCREEN_H   = 120;
    localparam int SPR_W      = 16;
    localparam int SPR_H      = 8;
    localparam int PLAYER_Y   = 104;
    localparam int LANE0_X    = 32;
    localparam int LANE_PITCH = 40;

    localparam logic [2:0] COL_BLACK = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b100;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b001;
    localparam logic [2:0] COL_OBS   = COL_RED;
    localparam logic [2:0] COL_PLR   = COL_BLUE;

    // endScreen outranks startScreen, which outranks gameScreen
    function automatic mode_t decode_mode(input logic start_s, input logic end_s,
                                          input logic game_s);
        if (end_s)        return MODE_END;
        else if (start_s) return MODE_START;
        else if (game_s)  return MODE_GAME;
        else              return MODE_BLANK;
    endfunction

    function automatic logic [2:0] fill_colour(input mode_t m);
        case (m)
            MODE_END:   return COL_RED;
            MODE_START: return COL_GREEN;
            default:    return COL_BLACK;
        endcase
    endfunction

    function automatic logic lane_valid(input logic [2:0] lane);
        return (lane == 3'b100) || (lane == 3'b010) || (lane == 3'b001);
    endfunction

    // one-hot lane to sprite x origin; non-one-hot lanes are never drawn
    function automatic logic [7:0] lane_x(input logic [2:0] lane);
        case (lane)
            3'b100:  return 8'(LANE0_X);
            3'b010:  return 8'(LANE0_X + LANE_PITCH);
            3'b001:  return 8'(LANE0_X + 2 * LANE_PITCH);
            default: return 8'd0;
        endcase
    endfunction

    // obstacle must fit entirely on screen to be drawn or erased
    function automatic logic obs_visible(input logic [2:0] lane, input logic [7:0] pos);
        return lane_valid(lane) && (pos <= 8'(SCREEN_H - SPR_H));
    endfunction

endpackage

// File: rtl/lane_render_ctrl_scanner.sv
// Row-major rectangle walker: a start pulse loads the origin and extent, then
// one (x, y) pair is emitted per cycle with valid high until the box is done.
module box_scanner
    import lane_render_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       valid,
    output logic       done
);

    logic [7:0] x_org;
    logic [7:0] x_end;
    logic [6:0] y_end;

    // load box on start, then step x, wrapping to the next row at x_end
    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= 8'd0;
            y     <= 7'd0;
            valid <= 1'b0;
            x_org <= 8'd0;
            x_end <= 8'd0;
            y_end <= 7'd0;
        end else if (start) begin
            x     <= x0;
            y     <= y0;
            x_org <= x0;
            x_end <= x0 + w - 8'd1;
            y_end <= y0 + h - 7'd1;
            valid <= 1'b1;
        end else if (valid) begin
            if (x == x_end) begin
                x <= x_org;
                if (y == y_end) valid <= 1'b0;
                else            y     <= y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    assign done = valid && (x == x_end) && (y == y_end);

endmodule

// File: rtl/lane_render_ctrl.sv
// Turns screen mode and lane/obstacle positions into a VGA pixel-write stream,
// redrawing only what changed since the last snapshot.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | compare live inputs against snapshot, busy low
// FILL      | whole screen in the snapshot mode's colour
// ERASE_OBS | old obstacle box in black (skipped if it was not drawn)
// ERASE_PLR | old player box in black (skipped for a bad lane)
// DRAW_OBS  | new positions captured on entry, obstacle box drawn
// DRAW_PLR  | player box drawn
// DONE      | single cycle, back to IDLE
module lane_render_ctrl
    import lane_render_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       startScreen,
    input  logic       endScreen,
    input  logic       gameScreen,
    input  logic [2:0] playerPos,
    input  logic [2:0] obstaclePos,
    input  logic [7:0] position,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy
);

    state_t     state_q, state_d;
    logic       first_q;
    mode_t      mode_live, snap_mode;
    logic [2:0] snap_plr, snap_obs;
    logic [7:0] snap_pos;

    logic       start, skip, scan_done;
    logic [7:0] box_x0, box_w;
    logic [6:0] box_y0, box_h;
    logic [2:0] box_col;

    assign mode_live = decode_mode(startScreen, endScreen, gameScreen);

    box_scanner u_scan (
        .clock (clock),
        .reset (reset),
        .start (start),
        .x0    (box_x0),
        .y0    (box_y0),
        .w     (box_w),
        .h     (box_h),
        .x     (x),
        .y     (y),
        .valid (plot),
        .done  (scan_done)
    );

    // state register; first_q marks the entry cycle so each box starts once
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
        end
    end

    // next state and box parameters for the current step
    always_comb begin
        state_d = state_q;
        skip    = 1'b0;
        box_x0  = 8'd0;
        box_y0  = 7'd0;
        box_w   = 8'(SPR_W);
        box_h   = 7'(SPR_H);
        box_col = COL_BLACK;
        case (state_q)
            ST_IDLE: begin
                if (mode_live != snap_mode)
                    state_d = ST_FILL;
                else if (mode_live == MODE_GAME && (playerPos != snap_plr ||
                         obstaclePos != snap_obs || position != snap_pos))
                    state_d = ST_ERASE_OBS;
            end
            ST_FILL: begin
                box_w   = 8'(SCREEN_W);
                box_h   = 7'(SCREEN_H);
                box_col = fill_colour(snap_mode);
                if (scan_done) state_d = (snap_mode == MODE_GAME) ? ST_DRAW_OBS : ST_DONE;
            end
            ST_ERASE_OBS: begin
                box_x0 = lane_x(snap_obs);
                box_y0 = snap_pos[6:0];
                skip   = !obs_visible(snap_obs, snap_pos);
                if (skip || scan_done) state_d = ST_ERASE_PLR;
            end
            ST_ERASE_PLR: begin
                box_x0 = lane_x(snap_plr);
                box_y0 = 7'(PLAYER_Y);
                skip   = !lane_valid(snap_plr);
                if (skip || scan_done) state_d = ST_DRAW_OBS;
            end
            ST_DRAW_OBS: begin
                box_x0  = lane_x(snap_obs);
                box_y0  = snap_pos[6:0];
                box_col = COL_OBS;
                skip    = !obs_visible(snap_obs, snap_pos);
                if (skip || scan_done) state_d = ST_DRAW_PLR;
            end
            ST_DRAW_PLR: begin
                box_x0  = lane_x(snap_plr);
                box_y0  = 7'(PLAYER_Y);
                box_col = COL_PLR;
                skip    = !lane_valid(snap_plr);
                if (skip || scan_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign start = first_q && !skip && (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign busy  = (state_q != ST_IDLE);

    // snapshot: mode on entry to FILL, positions on entry to DRAW_OBS
    always_ff @(posedge clock) begin
        if (reset) begin
            snap_mode <= MODE_BLANK;
            snap_plr  <= 3'b000;
            snap_obs  <= 3'b000;
            snap_pos  <= 8'd0;
        end else begin
            if (state_q == ST_IDLE && state_d == ST_FILL)
                snap_mode <= mode_live;
            if (state_d == ST_DRAW_OBS && state_q != ST_DRAW_OBS) begin
                snap_plr <= playerPos;
                snap_obs <= obstaclePos;
                snap_pos <= position;
            end
        end
    end

    // colour is held for the whole box, aligned with the scanner's first pixel
    always_ff @(posedge clock) begin
        if (reset)      colour <= COL_BLACK;
        else if (start) colour <= box_col;
    end

endmodule

// File: tb/tb_lane_render_ctrl.sv
// Directed bench: drives mode/position changes, records every plotted pixel
// and compares the stream with hand-derived boxes.
module tb_lane_render_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       startScreen, endScreen, gameScreen;
    logic [2:0] playerPos, obstaclePos;
    logic [7:0] position;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    lane_render_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .startScreen (startScreen),
        .endScreen   (endScreen),
        .gameScreen  (gameScreen),
        .playerPos   (playerPos),
        .obstaclePos (obstaclePos),
        .position    (position),
        .x           (x),
        .y           (y),
        .colour      (colour),
        .plot        (plot),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // count recorded pixels in [base, base+w*h) that differ from the expected box
    function automatic int box_errs(input int base, input int x0, input int y0,
                                    input int w, input int h, input int col);
        int errs = 0;
        for (int k = 0; k < w * h; k++) begin
            if (base + k >= q.size()) errs++;
            else if (q[base+k].x != x0 + k % w || q[base+k].y != y0 + k / w ||
                     q[base+k].c != col) errs++;
        end
        return errs;
    endfunction

    function automatic int pix_xy(input int i);
        if (i < 0 || i >= q.size()) return -1;
        return q[i].x * 1000 + q[i].y;
    endfunction

    // record plots until busy has risen and fallen; optionally raise endScreen mid-way
    task automatic capture(input int mid_at);
        bit started = 0;
        bit fin = 0;
        q.delete();
        for (int cyc = 0; cyc < 25000 && !fin; cyc++) begin
            @(negedge clock);
            if (busy) started = 1;
            if (plot) q.push_back('{int'(x), int'(y), int'(colour)});
            if (mid_at > 0 && q.size() == mid_at) endScreen = 1'b1;
            if (started && !busy) fin = 1;
        end
        check("seq_complete", int'(fin), 1);
    endtask

    initial begin
        reset = 1'b1;
        startScreen = 1'b0; endScreen = 1'b0; gameScreen = 1'b0;
        playerPos = 3'b000; obstaclePos = 3'b000; position = 8'd0;
        repeat (3) @(negedge clock);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_no_busy", int'(busy), 0);

        // start screen: full green fill
        startScreen = 1'b1;
        @(negedge clock);
        check("start_busy", int'(busy), 1);
        capture(0);
        check("start_count", q.size(), 19200);
        check("start_first", pix_xy(0), 0);
        check("start_last", pix_xy(19199), 159 * 1000 + 119);
        check("start_box", box_errs(0, 0, 0, 160, 120, 3'b010), 0);
        check("start_busy_end", int'(busy), 0);

        // enter game: black fill, obstacle at left lane y20, player mid lane
        startScreen = 1'b0; gameScreen = 1'b1;
        playerPos = 3'b010; obstaclePos = 3'b100; position = 8'd20;
        capture(0);
        check("game_count", q.size(), 19200 + 256);
        check("game_fill", box_errs(0, 0, 0, 160, 120, 0), 0);
        check("game_obs", box_errs(19200, 32, 20, 16, 8, 3'b100), 0);
        check("game_plr", box_errs(19328, 72, 104, 16, 8, 3'b001), 0);

        // obstacle moves 20 -> 24: erase both, redraw both, no fill
        position = 8'd24;
        capture(0);
        check("mv_count", q.size(), 512);
        check("mv_erase_obs", box_errs(0, 32, 20, 16, 8, 0), 0);
        check("mv_erase_plr", box_errs(128, 72, 104, 16, 8, 0), 0);
        check("mv_draw_obs", box_errs(256, 32, 24, 16, 8, 3'b100), 0);
        check("mv_draw_plr", box_errs(384, 72, 104, 16, 8, 3'b001), 0);

        // obstacle leaves the screen: old one erased, new one not drawn
        position = 8'd115;
        capture(0);
        check("off_count", q.size(), 384);
        check("off_erase_obs", box_errs(0, 32, 24, 16, 8, 0), 0);
        check("off_erase_plr", box_errs(128, 72, 104, 16, 8, 0), 0);
        check("off_draw_plr", box_errs(256, 72, 104, 16, 8, 3'b001), 0);

        // both old and new obstacle off-screen: only the player is touched
        position = 8'd116;
        capture(0);
        check("off2_count", q.size(), 256);
        check("off2_erase_plr", box_errs(0, 72, 104, 16, 8, 0), 0);
        check("off2_draw_plr", box_errs(128, 72, 104, 16, 8, 3'b001), 0);

        // boundary: position 112 is the lowest drawable row; right lane player
        position = 8'd112; playerPos = 3'b001;
        capture(0);
        check("edge_count", q.size(), 384);
        check("edge_erase_plr", box_errs(0, 72, 104, 16, 8, 0), 0);
        check("edge_draw_obs", box_errs(128, 32, 112, 16, 8, 3'b100), 0);
        check("edge_draw_plr", box_errs(256, 112, 104, 16, 8, 3'b001), 0);

        // endScreen raised during the obstacle draw: sequence finishes, then red fill
        position = 8'd40;
        capture(300);
        check("mid_count", q.size(), 512);
        check("mid_draw_plr", box_errs(384, 112, 104, 16, 8, 3'b001), 0);
        capture(0);
        check("end_count", q.size(), 19200);
        check("end_box", box_errs(0, 0, 0, 160, 120, 3'b100), 0);

        // reset in the middle of a fill aborts it; refill restarts at origin
        endScreen = 1'b0; gameScreen = 1'b0; startScreen = 1'b1;
        repeat (50) @(negedge clock);
        check("pre_rst_plot", int'(plot), 1);
        reset = 1'b1;
        @(negedge clock);
        check("abort_plot", int'(plot), 0);
        check("abort_busy", int'(busy), 0);
        reset = 1'b0;
        capture(0);
        check("refill_count", q.size(), 19200);
        check("refill_first", pix_xy(0), 0);
        check("refill_box", box_errs(0, 0, 0, 160, 120, 3'b010), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
